// File: rtl/host_loader.sv
// Host-facing loader: decodes header-framed commands from a 32-bit valid/ready stream,
// assembles 4x4 weight tiles, writes instruction words and gates the core's reset.
module host_loader #(
    parameter int TILE_WORDS = 16,
    parameter int ADDR_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [31:0]             s_data,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [32*TILE_WORDS-1:0] tile_data,
    output logic                    instr_we,
    output logic [ADDR_W-1:0]       instr_addr,
    output logic [15:0]             instr_data,
    output logic                    core_rst,
    output logic                    busy,
    output logic                    err
);

    localparam int CNT_W = $clog2(TILE_WORDS);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(TILE_WORDS - 1);

    localparam logic [1:0] CMD_LOAD_TILE  = 2'd0;
    localparam logic [1:0] CMD_LOAD_INSTR = 2'd1;
    localparam logic [1:0] CMD_RUN        = 2'd2;
    localparam logic [1:0] CMD_HALT       = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        TWRITE,
        IWRITE
    } state_t;

    state_t                    state_q,     state_d;
    logic [CNT_W-1:0]          wordCnt_q,   wordCnt_d;
    logic [ADDR_W-1:0]         tileAddr_q,  tileAddr_d;
    logic [32*TILE_WORDS-1:0]  tile_q,      tile_d;
    logic [ADDR_W-1:0]         instrAddr_q, instrAddr_d;
    logic [15:0]               instrData_q, instrData_d;
    logic                      coreRst_q,   coreRst_d;
    logic                      err_q,       err_d;

    logic       accept;
    logic [1:0] hdrCmd;
    logic       unused_hdrBits;

    assign hdrCmd         = s_data[31:30];
    assign unused_hdrBits = ^s_data[29:24];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wordCnt_q   <= '0;
            tileAddr_q  <= '0;
            tile_q      <= '0;
            instrAddr_q <= '0;
            instrData_q <= '0;
            coreRst_q   <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wordCnt_q   <= wordCnt_d;
            tileAddr_q  <= tileAddr_d;
            tile_q      <= tile_d;
            instrAddr_q <= instrAddr_d;
            instrData_q <= instrData_d;
            coreRst_q   <= coreRst_d;
            err_q       <= err_d;
        end
    end

    // Loads are only legal while the core is held in reset; otherwise the header is
    // swallowed and the sticky error flag raised.
    always_comb begin
        state_d     = state_q;
        wordCnt_d   = wordCnt_q;
        tileAddr_d  = tileAddr_q;
        tile_d      = tile_q;
        instrAddr_d = instrAddr_q;
        instrData_d = instrData_q;
        coreRst_d   = coreRst_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (hdrCmd)
                        CMD_LOAD_TILE: begin
                            if (coreRst_q) begin
                                tileAddr_d = ADDR_W'(s_data[23:16]);
                                wordCnt_d  = '0;
                                state_d    = COLLECT;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        CMD_LOAD_INSTR: begin
                            if (coreRst_q) begin
                                instrAddr_d = ADDR_W'(s_data[23:16]);
                                instrData_d = s_data[15:0];
                                state_d     = IWRITE;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        CMD_RUN: begin
                            coreRst_d = 1'b0;
                        end
                        CMD_HALT: begin
                            coreRst_d = 1'b1;
                            err_d     = 1'b0;
                        end
                        default: begin
                            state_d = IDLE;
                        end
                    endcase
                end
            end
            COLLECT: begin
                if (accept) begin
                    tile_d[32*wordCnt_q +: 32] = s_data;
                    if (wordCnt_q == LAST_WORD) begin
                        wordCnt_d = '0;
                        state_d   = TWRITE;
                    end else begin
                        wordCnt_d = wordCnt_q + 1'b1;
                    end
                end
            end
            TWRITE:  state_d = IDLE;
            IWRITE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ready is gated by rst directly so the host sees it low for the whole reset pulse.
    assign s_ready    = ~rst & ((state_q == IDLE) | (state_q == COLLECT));
    assign accept     = s_valid & s_ready;
    assign mem_we     = (state_q == TWRITE);
    assign instr_we   = (state_q == IWRITE);
    assign mem_addr   = tileAddr_q;
    assign tile_data  = tile_q;
    assign instr_addr = instrAddr_q;
    assign instr_data = instrData_q;
    assign core_rst   = coreRst_q;
    assign busy       = (state_q != IDLE);
    assign err        = err_q;

endmodule

// File: tb/tb_host_loader.sv
// Scoreboard bench for host_loader: stimulus pushes expected writes, a negedge monitor
// pops and compares them whenever a write strobe appears.
module tb_host_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic         mem_we;
    logic [7:0]   mem_addr;
    logic [511:0] tile_data;
    logic         instr_we;
    logic [7:0]   instr_addr;
    logic [15:0]  instr_data;
    logic         core_rst;
    logic         busy;
    logic         err;

    host_loader #(.TILE_WORDS(16), .ADDR_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .tile_data  (tile_data),
        .instr_we   (instr_we),
        .instr_addr (instr_addr),
        .instr_data (instr_data),
        .core_rst   (core_rst),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]   addr;
        logic [511:0] data;
        int           cyc;
    } tileExp_t;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
        int          cyc;
    } instrExp_t;

    tileExp_t  tileQ[$];
    instrExp_t instrQ[$];

    int cyc = 0;
    int nChecks = 0;
    int nFails = 0;
    int memWeCount = 0;
    int instrWeCount = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic noteFail(input string name, input string what);
        nChecks++;
        nFails++;
        $display("[TB] FAIL %s: %s", name, what);
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                memWeCount++;
                if (tileQ.size() == 0) begin
                    noteFail("unexpected_mem_we", $sformatf("strobe at cycle %0d, addr %0h", cyc, mem_addr));
                end else begin
                    tileExp_t e;
                    e = tileQ.pop_front();
                    checkOutput("mem_addr", 512'(mem_addr), 512'(e.addr));
                    checkOutput("tile_data", tile_data, e.data);
                    checkOutput("s_ready_in_twrite", 512'(s_ready), 512'(0));
                    if (e.cyc >= 0) checkOutput("mem_we_cycle", 512'(cyc), 512'(e.cyc));
                end
            end
            if (instr_we) begin
                instrWeCount++;
                if (instrQ.size() == 0) begin
                    noteFail("unexpected_instr_we", $sformatf("strobe at cycle %0d, addr %0h", cyc, instr_addr));
                end else begin
                    instrExp_t e;
                    e = instrQ.pop_front();
                    checkOutput("instr_addr", 512'(instr_addr), 512'(e.addr));
                    checkOutput("instr_data", 512'(instr_data), 512'(e.data));
                    checkOutput("s_ready_in_iwrite", 512'(s_ready), 512'(0));
                    checkOutput("instr_we_cycle", 512'(cyc), 512'(e.cyc));
                end
            end
        end
    end

    // Drives one word and returns the cycle number of the edge that accepted it.
    task automatic applyStimulus(input logic [31:0] w, input bit stall, output int acc);
        int n;
        if (stall) begin
            while ($urandom_range(1, 0) == 1) begin
                s_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        s_valid = 1'b1;
        s_data  = w;
        n = 0;
        while (!s_ready && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!s_ready) begin
            noteFail("s_ready_timeout", $sformatf("word %0h never accepted", w));
            s_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        s_valid = 1'b0;
    endtask

    task automatic sendTile(input logic [7:0] addr, input logic [31:0] base, input bit stall, input bit timed);
        tileExp_t e;
        int acc;
        e.addr = addr;
        for (int i = 0; i < 16; i++) e.data[32*i +: 32] = base + 32'(i);
        applyStimulus({2'd0, 6'd0, addr, 16'd0}, stall, acc);
        e.cyc = timed ? acc + 16 : -1;
        tileQ.push_back(e);
        for (int i = 0; i < 16; i++) applyStimulus(base + 32'(i), stall, acc);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        instrExp_t ie;

        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        idleCycles(3);
        checkOutput("s_ready_during_rst", 512'(s_ready), 512'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_s_ready", 512'(s_ready), 512'(1));
        checkOutput("rst_core_rst", 512'(core_rst), 512'(1));
        checkOutput("rst_mem_we", 512'(mem_we), 512'(0));
        checkOutput("rst_instr_we", 512'(instr_we), 512'(0));
        checkOutput("rst_busy", 512'(busy), 512'(0));
        checkOutput("rst_err", 512'(err), 512'(0));
        checkOutput("rst_mem_addr", 512'(mem_addr), 512'(0));
        checkOutput("rst_instr_data", 512'(instr_data), 512'(0));
        checkOutput("rst_tile_data", tile_data, 512'(0));

        // LOAD_INSTR addr 0x05 payload 0x0A03
        applyStimulus(32'h4005_0A03, 1'b0, acc);
        ie.addr = 8'h05;
        ie.data = 16'h0A03;
        ie.cyc  = acc;
        instrQ.push_back(ie);
        idleCycles(2);

        // Tile at 0x10, words 1..16, no stalls, then again with random stalls
        sendTile(8'h10, 32'd1, 1'b0, 1'b1);
        sendTile(8'h10, 32'd1, 1'b1, 1'b0);
        idleCycles(3);

        // RUN, then loads are rejected and data words become headers
        applyStimulus(32'h8000_0000, 1'b0, acc);
        checkOutput("run_core_rst", 512'(core_rst), 512'(0));
        checkOutput("run_err", 512'(err), 512'(0));
        applyStimulus(32'h0010_0000, 1'b0, acc);
        checkOutput("rejected_tile_err", 512'(err), 512'(1));
        checkOutput("rejected_tile_busy", 512'(busy), 512'(0));
        applyStimulus(32'd1, 1'b0, acc);
        applyStimulus(32'd2, 1'b0, acc);
        checkOutput("data_as_header_busy", 512'(busy), 512'(0));
        applyStimulus(32'h4007_1234, 1'b0, acc);
        checkOutput("rejected_instr_err", 512'(err), 512'(1));
        checkOutput("run_instr_addr_held", 512'(instr_addr), 512'(8'h05));
        applyStimulus(32'hC000_0000, 1'b0, acc);
        checkOutput("halt_core_rst", 512'(core_rst), 512'(1));
        checkOutput("halt_err", 512'(err), 512'(0));

        // Reset pulse after 7 of 16 tile words discards the tile
        applyStimulus(32'h0033_0000, 1'b0, acc);
        for (int i = 0; i < 7; i++) applyStimulus(32'hDEAD_0000 + 32'(i), 1'b0, acc);
        checkOutput("mid_tile_busy", 512'(busy), 512'(1));
        @(negedge clk);
        rst = 1'b1;
        #2;
        checkOutput("pulse_busy", 512'(busy), 512'(0));
        checkOutput("pulse_s_ready", 512'(s_ready), 512'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("pulse_tile_cleared", tile_data, 512'(0));
        checkOutput("pulse_mem_addr", 512'(mem_addr), 512'(0));
        checkOutput("pulse_core_rst", 512'(core_rst), 512'(1));
        idleCycles(4);

        sendTile(8'h22, 32'h1000_0000, 1'b0, 1'b1);
        idleCycles(5);

        checkOutput("tile_queue_drained", 512'(tileQ.size()), 512'(0));
        checkOutput("instr_queue_drained", 512'(instrQ.size()), 512'(0));
        checkOutput("mem_we_total", 512'(memWeCount), 512'(3));
        checkOutput("instr_we_total", 512'(instrWeCount), 512'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
